uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//   Parametrised UART transmitter, successor to the fixed 8E1 transmitter. Serialises one word per frame:
//   start, DATA_BITS data LSB-first, optional parity, 1 or 2 stop bits.
//   Has a ready/valid upstream handshake, a done pulse and back-to-back frames with no idle gap.
//   Sits between the bus-side register block and the pad.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD        115_200     line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer divide, DIV >= 2)
//   DATA_BITS   8           data bits per frame, legal 5..9
//   PARITY      0           0 none, 1 even, 2 odd
//   STOP_BITS   1           legal 1 or 2
//   FIFO_DEPTH  4           entries, power of 2 >= 2; used only with UART_TX_FIFO_EN
// PORTS
//   clk         in   1              system clock, rising edge
//   rst         in   1              asynchronous, active-low reset
//   tx_data     in   DATA_BITS      word to send, sampled on accept
//   tx_valid    in   1              upstream word present
//   tx_ready    out  1              block can accept; accept = tx_valid & tx_ready at rising clk
//   serial_out  out  1              UART line, idle high
//   busy        out  1              high from first start-bit cycle to last stop-bit cycle inclusive
//   tx_done     out  1              one-cycle pulse in the last cycle of the last stop bit
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  queued words; tied 0 without UART_TX_FIFO_EN
// BEHAVIOUR
//   Reset (async, any state, mid-frame included):
//     serial_out=1, busy=0, tx_done=0, tx_ready=0 while rst low; state IDLE; counters, shift reg, FIFO cleared.
//     Frame in flight is abandoned, not completed. tx_ready=1 from the first clock after rst releases.
//   FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE or START.
//   Bit timing: every bit is driven for exactly DIV clocks; 32-bit bit counter counts 0..DIV-1.
//   STOP lasts STOP_BITS*DIV clocks. Frame = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV clocks.
//   Accept: tx_data copied into shift register on the accept edge; later tx_data changes have no effect.
//   Latency: serial_out low in the cycle after the accept edge.
//   Parity: from the latched word, not from serial_out history. even: ^word; odd: ~^word.
//   tx_ready (no FIFO): high in IDLE and in the last cycle of the last stop bit.
//     Accept in that last cycle goes straight to START, so there is no idle gap between frames.
//   tx_valid without accept: no effect.
//   IDLE: serial_out=1, busy=0.
//   tx_done and accept in the same cycle are legal; both take effect.
// CONFIGURATION
//   Macro UART_TX_FIFO_EN.
//   Defined: FIFO of FIFO_DEPTH words ahead of the shift engine.
//     tx_ready = (fifo_level != FIFO_DEPTH).
//     Engine pops the head when IDLE and non-empty, or in the last stop cycle if non-empty.
//     Push into an empty FIFO while IDLE: start bit 2 cycles after the accept edge (write, then pop).
//     Simultaneous push and pop leaves fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
//     Push when full is impossible (tx_ready=0).
//   Undefined: no FIFO logic; direct handshake as above; fifo_level=0.
// STRUCTURE
//   Package uart_pkg: state encoding localparams (TX_IDLE..TX_STOP), parity mode constants
//     PAR_NONE/PAR_EVEN/PAR_ODD, function div_calc(clk_freq, baud).
//   Sub-module uart_tx_fifo (synchronous FIFO, push/pop/level), instantiated only under UART_TX_FIFO_EN.
//   All sequential logic: single clk domain, async active-low rst.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10)
//   1. DATA_BITS=8, PARITY=1, STOP=1, send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,0,1.
//      Each bit held 10 clks; parity 0; tx_done at clk 110 after accept; busy high 110 clks.
//   2. PARITY=2, DATA_BITS=7, STOP=2, send 7'h03 -> parity bit 1.
//      Stop high 20 clks; frame 110 clks.
//   3. PARITY=0, tx_valid held high with words 8'h00 then 8'hFF.
//      -> second start bit immediately follows the last stop cycle (zero gap); tx_ready high only in that cycle.
//   4. rst low at clk 35 of a frame -> serial_out=1 and busy=0 immediately.
//      After release the next accept sends a full, correct frame.
//   5. UART_TX_FIFO_EN, FIFO_DEPTH=4, push 5 words back-to-back while idle.
//      -> tx_ready drops when fifo_level=4; all 5 words transmitted in order with no gaps; fifo_level returns 0.
//   6. Change tx_data 1 clk after accept of 8'h3C -> transmitted data bits still 8'h3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM states, parity modes, divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int unsigned div_calc(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO ahead of the UART shift engine; head word is visible combinationally.
// Push is ignored when full and pop when empty; level and pointers update on the clock edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_push && (r_level != LVL_FULL);
  assign w_pop      = i_pop && (r_level != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_level    = r_level;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, 1/2 stop); line goes low the cycle after accept.
// Optional word FIFO ahead of the engine with UART_TX_FIFO_EN; without it tx_ready is high only in IDLE and the last stop cycle.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned DIV       = div_calc(CLK_FREQ, BAUD);
  localparam logic [31:0] BIT_LAST  = 32'(DIV - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);
  localparam int          LW        = $clog2(FIFO_DEPTH) + 1;

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [31:0]            r_bit_cnt;
  logic [3:0]             r_data_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_run;
  logic                   w_bit_end;
  logic                   w_last_stop;
  logic                   w_slot;
  logic                   w_load;
  logic [DATA_BITS-1:0]   w_load_dat;

  assign w_bit_end   = (r_bit_cnt == BIT_LAST);
  assign w_last_stop = (r_state == TX_STOP) && w_bit_end && (r_stop_cnt == STOP_LAST);
  // r_run keeps the handshake closed until the first clock after reset release.
  assign w_slot      = r_run && ((r_state == TX_IDLE) || w_last_stop);

`ifdef UART_TX_FIFO_EN
  localparam logic [LW-1:0] LVL_FULL = FIFO_DEPTH[LW-1:0];
  logic            w_push;
  logic [LW-1:0]   w_level;

  assign tx_ready   = r_run && (w_level != LVL_FULL);
  assign w_push     = tx_valid && tx_ready;
  assign w_load     = w_slot && (w_level != '0);
  assign fifo_level = w_level;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (tx_data),
    .i_pop      (w_load),
    .o_head_dat (w_load_dat),
    .o_level    (w_level)
  );
`else
  assign tx_ready   = w_slot;
  assign w_load     = tx_valid && w_slot;
  assign w_load_dat = tx_data;
  assign fifo_level = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= TX_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:   if (w_load) w_state_nxt = TX_START;
      TX_START:  if (w_bit_end) w_state_nxt = TX_DATA;
      TX_DATA:   if (w_bit_end && (r_data_cnt == DATA_LAST))
                   w_state_nxt = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_bit_end) w_state_nxt = TX_STOP;
      TX_STOP:   if (w_last_stop) w_state_nxt = w_load ? TX_START : TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    serial_out = 1'b1;
    case (r_state)
      TX_START:  serial_out = 1'b0;
      TX_DATA:   serial_out = r_shift[0];
      TX_PARITY: serial_out = r_par;
      default:   serial_out = 1'b1;
    endcase
    busy    = (r_state != TX_IDLE);
    tx_done = w_last_stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_bit_cnt  <= '0;
      r_data_cnt <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if ((r_state == TX_IDLE) || w_bit_end) r_bit_cnt <= '0;
      else                                    r_bit_cnt <= r_bit_cnt + 32'd1;

      if (r_state != TX_DATA) begin
        r_data_cnt <= '0;
      end else if (w_bit_end) begin
        r_data_cnt <= r_data_cnt + 4'd1;
        r_shift    <= r_shift >> 1;
      end

      if (r_state != TX_STOP) r_stop_cnt <= 1'b0;
      else if (w_bit_end)     r_stop_cnt <= !w_last_stop;

      // Parity comes from the latched word so later tx_data changes cannot disturb it.
      if (w_load) begin
        r_shift <= w_load_dat;
        r_par   <= (PARITY == PAR_ODD) ? ~^w_load_dat : ^w_load_dat;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8E1, 7O2, 8N1) at DIV=10 checked against a bit-list frame model.
module tb_uart_tx_param;

  localparam int DIV = 10;
  localparam int NB [3]  = '{8, 7, 8};
  localparam int PAR [3] = '{1, 2, 0};
  localparam int STB [3] = '{1, 2, 1};

  typedef int bitq_t[$];

  logic             clk;
  logic             rst;
  logic [2:0][8:0]  v_data;
  logic [2:0]       v_valid;
  logic [2:0]       v_ready;
  logic [2:0]       v_so;
  logic [2:0]       v_busy;
  logic [2:0]       v_done;
  logic [2:0][2:0]  v_lvl;

  int checks = 0;
  int errors = 0;
  logic [8:0] wq[$];

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(v_data[0][7:0]), .tx_valid(v_valid[0]), .tx_ready(v_ready[0]),
    .serial_out(v_so[0]), .busy(v_busy[0]), .tx_done(v_done[0]), .fifo_level(v_lvl[0]));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_data(v_data[1][6:0]), .tx_valid(v_valid[1]), .tx_ready(v_ready[1]),
    .serial_out(v_so[1]), .busy(v_busy[1]), .tx_done(v_done[1]), .fifo_level(v_lvl[1]));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .tx_data(v_data[2][7:0]), .tx_valid(v_valid[2]), .tx_ready(v_ready[2]),
    .serial_out(v_so[2]), .busy(v_busy[2]), .tx_done(v_done[2]), .fifo_level(v_lvl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame, one entry per bit period.
  function automatic bitq_t frame_bits(input int idx, input logic [8:0] w);
    bitq_t q;
    int ones = 0;
    q.push_back(0);
    for (int i = 0; i < NB[idx]; i++) begin
      q.push_back(int'(w[i]));
      ones += int'(w[i]);
    end
    if (PAR[idx] == 1)      q.push_back(ones % 2);
    else if (PAR[idx] == 2) q.push_back(1 - (ones % 2));
    for (int i = 0; i < STB[idx]; i++) q.push_back(1);
    return q;
  endfunction

  task automatic wait_ready(input int idx);
    int g = 0;
    while (v_ready[idx] !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("ready_wait_u%0d", idx), 32'(v_ready[idx]), 32'd1);
  endtask

  // Sends every word in wq on instance idx; hold keeps tx_valid high to chain frames.
  task automatic run_frames(input int idx, input bit hold);
    bitq_t exp;
    int fr;
    int n = wq.size();
    wait_ready(idx);
    v_data[idx]  = wq[0];
    v_valid[idx] = 1'b1;
    @(negedge clk);
    for (int j = 0; j < n; j++) begin
      exp = frame_bits(idx, wq[j]);
      fr  = exp.size() * DIV;
      if (hold && (j + 1 < n)) begin
        v_data[idx] = wq[j+1];
      end else begin
        v_valid[idx] = 1'b0;
        v_data[idx]  = 9'($urandom);
      end
`ifdef UART_TX_FIFO_EN
      chk($sformatf("fifo_wr_cycle_line_u%0d", idx), 32'(v_so[idx]), 32'd1);
      @(negedge clk);
`endif
      for (int k = 0; k < fr; k++) begin
        chk($sformatf("line_u%0d_f%0d_c%0d", idx, j, k), 32'(v_so[idx]), 32'(exp[k / DIV]));
        chk($sformatf("busy_u%0d_f%0d_c%0d", idx, j, k), 32'(v_busy[idx]), 32'd1);
        chk($sformatf("done_u%0d_f%0d_c%0d", idx, j, k), 32'(v_done[idx]), 32'(k == fr - 1));
`ifdef UART_TX_FIFO_EN
        chk($sformatf("ready_u%0d_f%0d_c%0d", idx, j, k), 32'(v_ready[idx]), 32'd1);
`else
        chk($sformatf("ready_u%0d_f%0d_c%0d", idx, j, k), 32'(v_ready[idx]), 32'(k == fr - 1));
`endif
        @(negedge clk);
      end
    end
    chk($sformatf("idle_line_u%0d", idx), 32'(v_so[idx]), 32'd1);
    chk($sformatf("idle_busy_u%0d", idx), 32'(v_busy[idx]), 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    v_data  = '0;
    v_valid = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_line_u%0d", i), 32'(v_so[i]), 32'd1);
      chk($sformatf("rst_busy_u%0d", i), 32'(v_busy[i]), 32'd0);
      chk($sformatf("rst_done_u%0d", i), 32'(v_done[i]), 32'd0);
      chk($sformatf("rst_ready_u%0d", i), 32'(v_ready[i]), 32'd0);
      chk($sformatf("rst_level_u%0d", i), 32'(v_lvl[i]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("post_rst_ready_u%0d", i), 32'(v_ready[i]), 32'd1);

    // 8E1 directed 0xA5 then random words
    wq = {9'h0A5};
    run_frames(0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      wq = {9'($urandom)};
      run_frames(0, 1'b0);
    end

    // 7O2 directed 0x03 then random words
    wq = {9'h003};
    run_frames(1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      wq = {9'($urandom)};
      run_frames(1, 1'b0);
    end

`ifdef UART_TX_FIFO_EN
    begin
      bitq_t stream;
      bitq_t fb;
      int total;
      int max_lvl = 0;
      wq = {};
      for (int i = 0; i < 5; i++) wq.push_back(9'($urandom));
      for (int i = 0; i < 5; i++) begin
        fb = frame_bits(2, wq[i]);
        foreach (fb[b]) stream.push_back(fb[b]);
      end
      total = stream.size() * DIV;
      wait_ready(2);
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            int g = 0;
            v_data[2]  = wq[i];
            v_valid[2] = 1'b1;
            while (v_ready[2] !== 1'b1 && g < 2000) begin
              @(negedge clk);
              g++;
            end
            @(negedge clk);
          end
          v_valid[2] = 1'b0;
          v_data[2]  = 9'($urandom);
        end
        begin
          @(negedge clk);
          chk("fifo_first_line", 32'(v_so[2]), 32'd1);
          chk("fifo_first_busy", 32'(v_busy[2]), 32'd0);
          for (int t = 1; t <= total + 1; t++) begin
            @(negedge clk);
            if (int'(v_lvl[2]) > max_lvl) max_lvl = int'(v_lvl[2]);
            chk($sformatf("fifo_ready_vs_level_t%0d", t), 32'(v_ready[2]), 32'(v_lvl[2] != 3'd4));
            if (t <= total) begin
              chk($sformatf("fifo_line_t%0d", t), 32'(v_so[2]), 32'(stream[(t-1) / DIV]));
              chk($sformatf("fifo_busy_t%0d", t), 32'(v_busy[2]), 32'd1);
              chk($sformatf("fifo_done_t%0d", t), 32'(v_done[2]), 32'(((t-1) % 100) == 99));
            end else begin
              chk("fifo_end_line", 32'(v_so[2]), 32'd1);
              chk("fifo_end_busy", 32'(v_busy[2]), 32'd0);
              chk("fifo_end_level", 32'(v_lvl[2]), 32'd0);
            end
          end
        end
      join
      chk("fifo_max_level", 32'(max_lvl), 32'd4);
    end
`else
    // 8N1 back-to-back: directed 00/FF then random words with tx_valid held
    wq = {9'h000, 9'h0FF};
    run_frames(2, 1'b1);
    wq = {};
    for (int i = 0; i < 4; i++) wq.push_back(9'($urandom));
    run_frames(2, 1'b1);
`endif

    // Reset in the middle of a frame, then a clean frame afterwards
    wait_ready(0);
    v_data[0]  = 9'($urandom);
    v_valid[0] = 1'b1;
    @(negedge clk);
    v_valid[0] = 1'b0;
    repeat (35) @(posedge clk);
    #2;
    chk("midframe_busy", 32'(v_busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_line", 32'(v_so[0]), 32'd1);
    chk("arst_busy", 32'(v_busy[0]), 32'd0);
    chk("arst_ready", 32'(v_ready[0]), 32'd0);
    chk("arst_done", 32'(v_done[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_ready_before_clk", 32'(v_ready[0]), 32'd0);
    @(negedge clk);
    chk("release_ready_after_clk", 32'(v_ready[0]), 32'd1);
    chk("release_line", 32'(v_so[0]), 32'd1);
    wq = {9'($urandom)};
    run_frames(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
